break_ctrl_mc: RTL and testbench
================================

Name: break_ctrl_mc

Overview:
- Multi-channel successor to the DUT clock-gating breakpoint logic. Produces the gated task-clock enable for the DUT.
- Halts the DUT on any of three triggers: a gated-cycle-count breakpoint, any of NUM_MON register-match breakpoints, or difftest_break.
- Supports resume and N-cycle single-step from halt, and reports the halt cause.
- Sits between the VIO/debug control plane and the DUT clock buffer.

Parameters:
- CNT_W, 64, width of the gated-cycle counter and cycle breakpoint.
- NUM_MON, 4, number of register-match channels.
- MON_W, 64, width of each monitored register.
- STEP_W, 16, width of the step count.

Ports:
- sys_clk  in  1  system clock.
- sys_resetn  in  1  reset.
- clk_en  in  1  global run enable from VIO.
- cycle_bp  in  CNT_W  cycle breakpoint value.
- cycle_bp_en  in  1  enables the cycle breakpoint.
- mon_data  in  NUM_MON*MON_W  monitored DUT registers; channel i = bits [i*MON_W +: MON_W].
- mon_bp  in  NUM_MON*MON_W  match values, same packing.
- mon_bp_en  in  NUM_MON  per-channel enable.
- dut_valid  in  1  qualifies mon_data.
- difftest_break  in  1  difftest mismatch, level.
- resume_req  in  1  pulse: leave halt.
- step_req  in  1  pulse: step from halt.
- step_count  in  STEP_W  number of cycles to step.
- task_clk_ce  out  1  registered clock enable for the DUT BUFGCE.
- halted  out  1  high in HALT.
- halt_cause  out  NUM_MON+3  {step_done, difftest, cycle, mon[NUM_MON-1:0]}, sticky until leaving HALT.
- gated_cycles  out  CNT_W  count of cycles with task_clk_ce=1.

Behaviour:
- Reset: asynchronous, active-low on sys_resetn; all state is cleared.
  - Reset values: state=IDLE, task_clk_ce=0, halted=0, halt_cause=0, gated_cycles=0, all re-arm flags=1.
- States: IDLE, RUN, HALT, STEP.
  - IDLE -> RUN when clk_en=1.
  - Any state -> IDLE when clk_en=0. halt_cause is held; gated_cycles is held.
- Trigger evaluation, every cycle in RUN and STEP:
  - Cycle trigger: cycle_bp_en && gated_cycles==cycle_bp.
  - Mon trigger i: mon_bp_en[i] && dut_valid && mon_data_i==mon_bp_i && rearm[i].
  - Difftest trigger: difftest_break.
- Any trigger true in cycle t: state becomes HALT at t+1 and task_clk_ce=0 from t+1. Exactly one gated cycle follows the triggering sample.
  - halt_cause at t+1 is the OR of all triggers true at t; simultaneous triggers all set their bits.
- task_clk_ce = registered (next_state is RUN or STEP).
- gated_cycles increments by 1 each cycle task_clk_ce=1 and wraps modulo 2^CNT_W.
- Re-arm rule:
  - rearm[i] clears when channel i triggers.
  - rearm[i] sets again when the channel i match is false for at least one cycle.
  - A persistent match therefore does not re-halt immediately after resume.
  - difftest_break is level-sensitive: if it is still high after resume, the block re-halts.
- HALT + resume_req -> RUN next cycle; halt_cause clears.
- HALT + step_req -> STEP:
  - Load step counter with max(step_count, 1).
  - Decrement once per gated cycle.
  - When it reaches 0 -> HALT with only step_done set.
  - A trigger during STEP wins: HALT with the trigger bits. If the last step cycle also triggers, step_done is also set.
- resume_req and step_req both high in HALT: resume wins.
- Either request outside HALT is ignored.
- Reset asserted mid-STEP or mid-RUN: task_clk_ce drops asynchronously and all state is cleared.

Optional Feature:
- Macro: BREAK_SNAPSHOT_EN.
- With the macro defined:
  - Adds output snap_data [NUM_MON*MON_W] and output snap_cycle [CNT_W].
  - On entry to HALT, both are loaded with mon_data and gated_cycles from the triggering cycle t.
  - Both hold until the next HALT entry; reset value 0.
- Without the macro: these ports and their registers are absent.

Decomposition:
- Package break_ctrl_pkg holds:
  - the state enum (IDLE, RUN, HALT, STEP);
  - halt_cause bit-index constants: CAUSE_STEP, CAUSE_DIFF, CAUSE_CYC, CAUSE_MON0.
- One sub-module, break_mon_ch: a single compare channel with its rearm flag.
  - Inputs: data, bp, en, valid, eval.
  - Output: trig.
  - Instantiated NUM_MON times via generate.

Test Plan:
- Cycle breakpoint: clk_en=1, cycle_bp_en=1, cycle_bp=10 -> halted=1 with gated_cycles=11; halt_cause=cycle only; task_clk_ce low from the next cycle.
- Mon channel 2: mon_data_2==mon_bp_2=0xDEAD with dut_valid=1 -> halt_cause=mon[2]. Then resume with the match held -> no re-halt. Then mismatch 1 cycle followed by a new match -> halts again.
- Simultaneous triggers: difftest_break and mon[0] in the same cycle -> both cause bits set. Resume with difftest_break still high -> re-halt with the difftest bit.
- Stepping from HALT:
  - step_count=3 -> exactly 3 task_clk_ce cycles, then halted with step_done only.
  - step_count=0 -> exactly 1 cycle.
- Run control and reset:
  - resume_req and step_req in the same cycle -> RUN.
  - clk_en=0 mid-RUN -> IDLE, ce=0, counter held.
  - sys_resetn low mid-STEP -> all outputs 0 without waiting for a clock edge.
- Counter wrap: CNT_W=8, run 260 gated cycles -> gated_cycles=4. cycle_bp=2 on the second pass -> halt.

Source files
------------

// File: rtl/break_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// break_ctrl_pkg
// Shared types and constants for the multi-channel DUT breakpoint controller.
//   state_e   : controller state (IDLE, RUN, HALT, STEP)
//   CAUSE_*   : halt_cause bit positions. Match channel i sits at CAUSE_MON0+i;
//               the fixed causes sit directly above the NUM_MON channel bits and
//               are expressed as offsets from NUM_MON (use cause_bit()).
// -----------------------------------------------------------------------------
package break_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        STEP = 2'd3
    } state_e;

    localparam int CAUSE_MON0 = 0;

    localparam int CAUSE_CYC  = 0;
    localparam int CAUSE_DIFF = 1;
    localparam int CAUSE_STEP = 2;

    // Absolute halt_cause index of a fixed cause for a given channel count.
    function automatic int cause_bit(input int num_mon, input int cause);
        return num_mon + cause;
    endfunction

endpackage

// File: rtl/break_mon_ch.sv
// -----------------------------------------------------------------------------
// break_mon_ch
// One register-match breakpoint channel with its re-arm flag.
//   sys_clk, sys_resetn : clock, async active-low reset
//   data  [MON_W]       : monitored DUT register
//   bp    [MON_W]       : match value
//   en                  : channel enable
//   valid               : qualifies data
//   eval                : controller is evaluating triggers this cycle
//   trig                : channel fires this cycle
// After firing, the channel stays disarmed until its match goes false for at
// least one cycle, so a persistent match cannot re-halt straight after resume.
// -----------------------------------------------------------------------------
module break_mon_ch #(
    parameter int MON_W = 64
) (
    input  logic             sys_clk,
    input  logic             sys_resetn,
    input  logic [MON_W-1:0] data,
    input  logic [MON_W-1:0] bp,
    input  logic             en,
    input  logic             valid,
    input  logic             eval,
    output logic             trig
);

    logic match;
    logic rearm_q, rearm_d;

    assign match = en && valid && (data == bp);
    assign trig  = match && rearm_q && eval;

    always_comb begin
        // NOTE: default first so every path assigns rearm_d and no latch is inferred.
        rearm_d = rearm_q;
        if (trig) begin
            rearm_d = 1'b0;
        end else if (!match) begin
            rearm_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        // NOTE: non-blocking for state so all flops update from pre-edge values.
        if (!sys_resetn) begin
            rearm_q <= 1'b1;
        end else begin
            rearm_q <= rearm_d;
        end
    end

endmodule

// File: rtl/break_ctrl_mc.sv
// -----------------------------------------------------------------------------
// break_ctrl_mc
// Gated task-clock enable generator with cycle, register-match and difftest
// breakpoints, resume and N-cycle single-step.
// Ports:
//   sys_clk, sys_resetn          : system clock, async active-low reset
//   clk_en                       : global run enable (low forces IDLE)
//   cycle_bp, cycle_bp_en        : gated-cycle breakpoint and its enable
//   mon_data, mon_bp [NUM_MON*MON_W] : monitored regs / match values, ch i at [i*MON_W +: MON_W]
//   mon_bp_en [NUM_MON]          : per-channel enable
//   dut_valid                    : qualifies mon_data
//   difftest_break               : difftest mismatch (level)
//   resume_req, step_req         : pulses, honoured only in HALT (resume wins)
//   step_count [STEP_W]          : cycles to step (0 treated as 1)
//   task_clk_ce                  : registered enable for the DUT clock buffer
//   halted                       : high in HALT
//   halt_cause [NUM_MON+3]       : {step_done, difftest, cycle, mon[NUM_MON-1:0]}
//   gated_cycles [CNT_W]         : count of cycles with task_clk_ce=1 (wraps)
// Optional (macro BREAK_SNAPSHOT_EN):
//   snap_data [NUM_MON*MON_W], snap_cycle [CNT_W] : mon_data and gated_cycles
//   captured from the triggering cycle on each HALT entry.
// -----------------------------------------------------------------------------
module break_ctrl_mc
    import break_ctrl_pkg::*;
#(
    parameter int CNT_W   = 64,
    parameter int NUM_MON = 4,
    parameter int MON_W   = 64,
    parameter int STEP_W  = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_resetn,
    input  logic                     clk_en,
    input  logic [CNT_W-1:0]         cycle_bp,
    input  logic                     cycle_bp_en,
    input  logic [NUM_MON*MON_W-1:0] mon_data,
    input  logic [NUM_MON*MON_W-1:0] mon_bp,
    input  logic [NUM_MON-1:0]       mon_bp_en,
    input  logic                     dut_valid,
    input  logic                     difftest_break,
    input  logic                     resume_req,
    input  logic                     step_req,
    input  logic [STEP_W-1:0]        step_count,
    output logic                     task_clk_ce,
    output logic                     halted,
    output logic [NUM_MON+2:0]       halt_cause,
    output logic [CNT_W-1:0]         gated_cycles
`ifdef BREAK_SNAPSHOT_EN
    ,
    output logic [NUM_MON*MON_W-1:0] snap_data,
    output logic [CNT_W-1:0]         snap_cycle
`endif
);

    localparam int CAUSE_W  = NUM_MON + 3;
    localparam int IDX_CYC  = cause_bit(NUM_MON, CAUSE_CYC);
    localparam int IDX_DIFF = cause_bit(NUM_MON, CAUSE_DIFF);
    localparam int IDX_STEP = cause_bit(NUM_MON, CAUSE_STEP);

    state_e               state_q, state_d;
    logic                 ce_q, ce_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [CAUSE_W-1:0]   trig_vec;
    logic [NUM_MON-1:0]   mon_trig;
    logic                 eval;
    logic                 step_last;
    logic                 stop;

    // Triggers are only looked at while the DUT clock is actually running.
    assign eval      = clk_en && ((state_q == RUN) || (state_q == STEP));
    assign step_last = (state_q == STEP) && (step_q == STEP_W'(1));

    for (genvar i = 0; i < NUM_MON; i++) begin : g_mon
        break_mon_ch #(
            .MON_W (MON_W)
        ) u_ch (
            .sys_clk    (sys_clk),
            .sys_resetn (sys_resetn),
            .data       (mon_data[i*MON_W +: MON_W]),
            .bp         (mon_bp[i*MON_W +: MON_W]),
            .en         (mon_bp_en[i]),
            .valid      (dut_valid),
            .eval       (eval),
            .trig       (mon_trig[i])
        );
    end

    // All causes true in this cycle; the last step cycle counts as a cause so
    // that a trigger on that cycle reports both.
    always_comb begin
        trig_vec                        = '0;
        trig_vec[CAUSE_MON0 +: NUM_MON] = mon_trig;
        trig_vec[IDX_CYC]               = eval && cycle_bp_en && (cnt_q == cycle_bp);
        trig_vec[IDX_DIFF]              = eval && difftest_break;
        trig_vec[IDX_STEP]              = eval && step_last;
    end

    assign stop = |trig_vec;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        step_d  = step_q;
        if (!clk_en) begin
            // halt_cause and the counter are deliberately held here.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (stop) begin
                        state_d = HALT;
                        cause_d = trig_vec;
                    end
                end
                HALT: begin
                    if (resume_req) begin
                        state_d = RUN;
                        cause_d = '0;
                    end else if (step_req) begin
                        state_d = STEP;
                        cause_d = '0;
                        step_d  = (step_count == '0) ? STEP_W'(1) : step_count;
                    end
                end
                STEP: begin
                    step_d = step_q - STEP_W'(1);
                    if (stop) begin
                        state_d = HALT;
                        cause_d = trig_vec;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The enable is registered from next-state: a trigger in cycle t leaves
    // exactly that cycle gated and drops the enable from t+1.
    assign ce_d  = (state_d == RUN) || (state_d == STEP);
    assign cnt_d = cnt_q + CNT_W'(ce_q);

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q <= IDLE;
            ce_q    <= 1'b0;
            cnt_q   <= '0;
            cause_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            step_q  <= step_d;
        end
    end

    assign task_clk_ce  = ce_q;
    assign halted       = (state_q == HALT);
    assign halt_cause   = cause_q;
    assign gated_cycles = cnt_q;

`ifdef BREAK_SNAPSHOT_EN
    logic                     halt_entry;
    logic [NUM_MON*MON_W-1:0] snap_data_q;
    logic [CNT_W-1:0]         snap_cycle_q;

    assign halt_entry = (state_d == HALT) && (state_q != HALT);

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            snap_data_q  <= '0;
            snap_cycle_q <= '0;
        end else if (halt_entry) begin
            snap_data_q  <= mon_data;
            snap_cycle_q <= cnt_q;
        end
    end

    assign snap_data  = snap_data_q;
    assign snap_cycle = snap_cycle_q;
`endif

endmodule

// File: tb/tb_break_ctrl_mc.sv
`timescale 1ns/1ps
module tb_break_ctrl_mc;

    localparam int CNT_W   = 8;
    localparam int NUM_MON = 4;
    localparam int MON_W   = 64;
    localparam int STEP_W  = 16;

    // Expected halt_cause encodings: {step, diff, cyc, mon[3:0]}
    localparam logic [6:0] C_CYC   = 7'b001_0000;
    localparam logic [6:0] C_MON2  = 7'b000_0100;
    localparam logic [6:0] C_DFM0  = 7'b010_0001;
    localparam logic [6:0] C_DIFF  = 7'b010_0000;
    localparam logic [6:0] C_STEP  = 7'b100_0000;

    logic                     sys_clk = 1'b0;
    logic                     sys_resetn;
    logic                     clk_en;
    logic [CNT_W-1:0]         cycle_bp;
    logic                     cycle_bp_en;
    logic [NUM_MON*MON_W-1:0] mon_data;
    logic [NUM_MON*MON_W-1:0] mon_bp;
    logic [NUM_MON-1:0]       mon_bp_en;
    logic                     dut_valid;
    logic                     difftest_break;
    logic                     resume_req;
    logic                     step_req;
    logic [STEP_W-1:0]        step_count;
    logic                     task_clk_ce;
    logic                     halted;
    logic [NUM_MON+2:0]       halt_cause;
    logic [CNT_W-1:0]         gated_cycles;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected halt causes, pushed when the stimulus is set up,
    // popped by the monitor on each rising edge of halted.
    logic [NUM_MON+2:0] exp_q[$];
    logic [CNT_W-1:0]   model_cnt;
    logic               halted_prev;

    always #5 sys_clk = ~sys_clk;

    break_ctrl_mc #(
        .CNT_W   (CNT_W),
        .NUM_MON (NUM_MON),
        .MON_W   (MON_W),
        .STEP_W  (STEP_W)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_resetn     (sys_resetn),
        .clk_en         (clk_en),
        .cycle_bp       (cycle_bp),
        .cycle_bp_en    (cycle_bp_en),
        .mon_data       (mon_data),
        .mon_bp         (mon_bp),
        .mon_bp_en      (mon_bp_en),
        .dut_valid      (dut_valid),
        .difftest_break (difftest_break),
        .resume_req     (resume_req),
        .step_req       (step_req),
        .step_count     (step_count),
        .task_clk_ce    (task_clk_ce),
        .halted         (halted),
        .halt_cause     (halt_cause),
        .gated_cycles   (gated_cycles)
    );

    // Monitor: counts gated cycles seen on task_clk_ce and checks every halt entry.
    always @(negedge sys_clk) begin
        logic [NUM_MON+2:0] exp;
        if (!sys_resetn) begin
            model_cnt   = '0;
            halted_prev = 1'b0;
        end else begin
            if (halted === 1'b1 && halted_prev !== 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_halt cause=%b", halt_cause);
                end else begin
                    exp = exp_q.pop_front();
                    if (halt_cause !== exp) begin
                        failures++;
                        $display("FAIL halt_cause got=%b exp=%b", halt_cause, exp);
                    end
                    checks++;
                    if (gated_cycles !== model_cnt) begin
                        failures++;
                        $display("FAIL halt_gated got=%0d exp=%0d", gated_cycles, model_cnt);
                    end
                    checks++;
                    if (task_clk_ce !== 1'b0) begin
                        failures++;
                        $display("FAIL halt_ce got=%b exp=0", task_clk_ce);
                    end
                end
            end
            if (task_clk_ce === 1'b1) model_cnt = model_cnt + 1'b1;
            halted_prev = halted;
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_halted(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        sys_resetn     = 1'b0;
        clk_en         = 1'b0;
        cycle_bp       = '0;
        cycle_bp_en    = 1'b0;
        mon_data       = '0;
        mon_bp         = '0;
        mon_bp_en      = '0;
        dut_valid      = 1'b0;
        difftest_break = 1'b0;
        resume_req     = 1'b0;
        step_req       = 1'b0;
        step_count     = '0;
        ticks(2);
        sys_resetn = 1'b1;
        tick();
    endtask

    task automatic pulse_resume();
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
    endtask

    task automatic test_reset();
        sys_resetn = 1'b0;
        #2;
        checks++;
        if ({task_clk_ce, halted, halt_cause, gated_cycles} !== '0) begin
            failures++;
            $display("FAIL reset_values ce=%b halted=%b cause=%b cnt=%0d exp=all0",
                     task_clk_ce, halted, halt_cause, gated_cycles);
        end
        do_reset();
        ticks(2);
        checks++;
        if (task_clk_ce !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold ce=%b halted=%b exp=0/0", task_clk_ce, halted);
        end
    endtask

    task automatic test_cycle_bp();
        bit ok;
        do_reset();
        cycle_bp    = 8'd10;
        cycle_bp_en = 1'b1;
        exp_q.push_back(C_CYC);
        clk_en = 1'b1;
        wait_halted(40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL cyc_bp_timeout halted=%b exp=1", halted);
        end
        checks++;
        if (gated_cycles !== 8'd11) begin
            failures++;
            $display("FAIL cyc_bp_count got=%0d exp=11", gated_cycles);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || task_clk_ce !== 1'b0 || halt_cause !== C_CYC) begin
            failures++;
            $display("FAIL cyc_bp_sticky halted=%b ce=%b cause=%b exp=1/0/%b",
                     halted, task_clk_ce, halt_cause, C_CYC);
        end
        cycle_bp_en = 1'b0;
        pulse_resume();
        checks++;
        if (halted !== 1'b0 || task_clk_ce !== 1'b1 || halt_cause !== '0) begin
            failures++;
            $display("FAIL cyc_resume halted=%b ce=%b cause=%b exp=0/1/0",
                     halted, task_clk_ce, halt_cause);
        end
    endtask

    task automatic test_mon_rearm();
        bit ok;
        do_reset();
        mon_bp[2*MON_W +: MON_W]   = 64'hDEAD;
        mon_data[2*MON_W +: MON_W] = 64'hDEAD;
        mon_bp_en                  = 4'b0100;
        dut_valid                  = 1'b1;
        exp_q.push_back(C_MON2);
        clk_en = 1'b1;
        wait_halted(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mon2_timeout halted=%b exp=1", halted);
        end
        pulse_resume();
        ticks(6);
        checks++;
        if (halted !== 1'b0 || task_clk_ce !== 1'b1) begin
            failures++;
            $display("FAIL mon2_no_rehalt halted=%b ce=%b exp=0/1", halted, task_clk_ce);
        end
        mon_data[2*MON_W +: MON_W] = 64'h0;
        tick();
        mon_data[2*MON_W +: MON_W] = 64'hDEAD;
        exp_q.push_back(C_MON2);
        wait_halted(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mon2_rearm_timeout halted=%b exp=1", halted);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        mon_bp[0 +: MON_W] = 64'h1234;
        mon_bp_en          = 4'b0001;
        dut_valid          = 1'b1;
        clk_en             = 1'b1;
        ticks(3);
        exp_q.push_back(C_DFM0);
        mon_data[0 +: MON_W] = 64'h1234;
        difftest_break       = 1'b1;
        wait_halted(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL simul_timeout halted=%b exp=1", halted);
        end
        exp_q.push_back(C_DIFF);
        pulse_resume();
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL simul_resume halted=%b exp=0", halted);
        end
        wait_halted(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL diff_rehalt_timeout halted=%b exp=1", halted);
        end
        difftest_break = 1'b0;
        mon_bp_en      = '0;
    endtask

    task automatic run_step(input logic [STEP_W-1:0] cnt, input int exp_n, input string name);
        int n;
        bit ok;
        exp_q.push_back(C_STEP);
        step_count = cnt;
        step_req   = 1'b1;
        tick();
        step_req = 1'b0;
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (task_clk_ce === 1'b1) n++;
            tick();
        end
        checks++;
        if (!ok || n != exp_n) begin
            failures++;
            $display("FAIL %s halted=%b ce_cycles=%0d exp=%0d", name, ok, n, exp_n);
        end
    endtask

    task automatic test_step();
        bit ok;
        do_reset();
        difftest_break = 1'b1;
        exp_q.push_back(C_DIFF);
        clk_en = 1'b1;
        wait_halted(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL step_setup_timeout halted=%b exp=1", halted);
        end
        difftest_break = 1'b0;
        run_step(16'd3, 3, "step_3");
        run_step(16'd0, 1, "step_0");
    endtask

    task automatic test_run_control();
        // Entered in HALT from test_step.
        resume_req = 1'b1;
        step_req   = 1'b1;
        step_count = 16'd2;
        tick();
        resume_req = 1'b0;
        step_req   = 1'b0;
        ticks(6);
        checks++;
        if (halted !== 1'b0 || task_clk_ce !== 1'b1) begin
            failures++;
            $display("FAIL resume_wins halted=%b ce=%b exp=0/1", halted, task_clk_ce);
        end
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        ticks(4);
        checks++;
        if (halted !== 1'b0 || task_clk_ce !== 1'b1) begin
            failures++;
            $display("FAIL step_ignored halted=%b ce=%b exp=0/1", halted, task_clk_ce);
        end
        // clk_en drop mid-RUN from a known count.
        do_reset();
        clk_en = 1'b1;
        ticks(6);
        clk_en = 1'b0;
        ticks(4);
        checks++;
        if (task_clk_ce !== 1'b0 || halted !== 1'b0 || gated_cycles !== 8'd6) begin
            failures++;
            $display("FAIL clk_en_off ce=%b halted=%b cnt=%0d exp=0/0/6",
                     task_clk_ce, halted, gated_cycles);
        end
        clk_en = 1'b1;
        tick();
        checks++;
        if (task_clk_ce !== 1'b1 || gated_cycles !== 8'd6) begin
            failures++;
            $display("FAIL clk_en_on ce=%b cnt=%0d exp=1/6", task_clk_ce, gated_cycles);
        end
    endtask

    task automatic test_reset_mid_step();
        bit ok;
        do_reset();
        difftest_break = 1'b1;
        exp_q.push_back(C_DIFF);
        clk_en = 1'b1;
        wait_halted(10, ok);
        difftest_break = 1'b0;
        step_count     = 16'd10;
        step_req       = 1'b1;
        tick();
        step_req = 1'b0;
        ticks(2);
        checks++;
        if (!ok || task_clk_ce !== 1'b1) begin
            failures++;
            $display("FAIL midstep_setup halted_seen=%b ce=%b exp=1/1", ok, task_clk_ce);
        end
        sys_resetn = 1'b0;
        #1;
        checks++;
        if ({task_clk_ce, halted, halt_cause, gated_cycles} !== '0) begin
            failures++;
            $display("FAIL async_reset ce=%b halted=%b cause=%b cnt=%0d exp=all0",
                     task_clk_ce, halted, halt_cause, gated_cycles);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        clk_en = 1'b1;
        ticks(260);
        clk_en = 1'b0;
        ticks(2);
        checks++;
        if (gated_cycles !== 8'd4 || task_clk_ce !== 1'b0) begin
            failures++;
            $display("FAIL wrap_count cnt=%0d ce=%b exp=4/0", gated_cycles, task_clk_ce);
        end
        cycle_bp    = 8'd2;
        cycle_bp_en = 1'b1;
        exp_q.push_back(C_CYC);
        clk_en = 1'b1;
        wait_halted(300, ok);
        checks++;
        if (!ok || gated_cycles !== 8'd3) begin
            failures++;
            $display("FAIL wrap_bp halted=%b cnt=%0d exp=1/3", ok, gated_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_cycle_bp();
        test_mon_rearm();
        test_simultaneous();
        test_step();
        test_run_control();
        test_reset_mid_step();
        test_wrap();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
